// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad column scanner.
package keypad_pkg;

  // Scanner states: hunting for a key, confirming a press, holding, confirming a release.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Synchronized row value when no row is pulled low.
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Hex code for row r, column c: (4*r + c + 1) mod 16; the 4-bit add wraps 16 to 0.
  function automatic logic [3:0] row_code(input logic [1:0] r, input logic [1:0] c);
    return {r, 2'b00} + {2'b00, c} + 4'd1;
  endfunction

  // {valid, row index}: valid only when exactly one row line is low.
  function automatic logic [2:0] single_low(input logic [3:0] rs);
    logic [2:0] res;
    case (rs)
      4'b1110: res = 3'b1_00;
      4'b1101: res = 3'b1_01;
      4'b1011: res = 3'b1_10;
      4'b0111: res = 3'b1_11;
      default: res = 3'b0_00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad row lines.
module row_sync (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] i_async,
  output logic [3:0] o_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two-stage capture; resets to "no row low" so nothing looks pressed out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-shot key code output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [1:0] col_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

  logic [3:0]       w_rs;
  logic [DIV_W-1:0] r_dwell;
  logic             w_tick;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEB_W-1:0] r_deb;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [DEB_W-1:0] w_deb_inc;
  logic [1:0]       r_row;
  logic [1:0]       w_row_nxt;
  logic [1:0]       r_col;
  logic [1:0]       w_col_nxt;
  logic [3:0]       r_cols_n;
  logic             w_col_adv;
  logic             w_accept;
  logic             w_release_done;
  logic [2:0]       w_single;
  logic             w_valid;
  logic [1:0]       w_row_idx;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  row_sync u_row_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .i_async (rows_n),
    .o_sync  (w_rs)
  );

  assign w_tick    = (r_dwell == DIV_LAST);
  assign w_single  = single_low(w_rs);
  assign w_valid   = w_single[2];
  assign w_row_idx = w_single[1:0];
  assign w_deb_inc = r_deb + DEB_ONE;
  assign w_col_nxt = r_col + 2'd1;

  // Free-running dwell counter; its last count is the only sampling point.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
    end else if (w_tick) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + DIV_W'(1);
    end
  end

  // State, debounce count and captured row.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SCAN;
      r_deb   <= '0;
      r_row   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next-state logic; the column only moves when the scanner gives up on or finishes a key.
  always_comb begin
    w_state_nxt    = r_state;
    w_deb_nxt      = r_deb;
    w_row_nxt      = r_row;
    w_col_adv      = 1'b0;
    w_accept       = 1'b0;
    w_release_done = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_tick && w_valid) begin
          w_row_nxt = w_row_idx;
          w_deb_nxt = DEB_ONE;
          if (DEBOUNCE_CNT == 1) begin
            w_accept    = 1'b1;
            w_state_nxt = PRESSED;
          end else begin
            w_state_nxt = DEBOUNCE;
          end
        end else if (w_tick) begin
          w_col_adv = 1'b1;
        end else begin
          w_state_nxt = SCAN;
        end
      end
      DEBOUNCE: begin
        if (w_tick && w_valid && (w_row_idx == r_row)) begin
          w_deb_nxt = w_deb_inc;
          if (w_deb_inc == DEB_TARGET) begin
            w_accept    = 1'b1;
            w_state_nxt = PRESSED;
          end else begin
            w_state_nxt = DEBOUNCE;
          end
        end else if (w_tick) begin
          w_state_nxt = SCAN;
          w_col_adv   = 1'b1;
        end else begin
          w_state_nxt = DEBOUNCE;
        end
      end
      PRESSED: begin
        if (w_tick && (w_rs == ROWS_IDLE)) begin
          w_deb_nxt = DEB_ONE;
          if (DEBOUNCE_CNT == 1) begin
            w_state_nxt    = SCAN;
            w_release_done = 1'b1;
            w_col_adv      = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_state_nxt = PRESSED;
        end
      end
      RELEASE: begin
        if (w_tick && (w_rs == ROWS_IDLE)) begin
          w_deb_nxt = w_deb_inc;
          if (w_deb_inc == DEB_TARGET) begin
            w_state_nxt    = SCAN;
            w_release_done = 1'b1;
            w_col_adv      = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else if (w_tick) begin
          w_state_nxt = PRESSED;
        end else begin
          w_state_nxt = RELEASE;
        end
      end
      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

  // Column strobe and index move together so the encoder never sees them disagree.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col    <= 2'd0;
      r_cols_n <= 4'b1110;
    end else if (w_col_adv) begin
      r_col    <= w_col_nxt;
      r_cols_n <= ~(4'b0001 << w_col_nxt);
    end else begin
      r_col    <= r_col;
      r_cols_n <= r_cols_n;
    end
  end

  // Key outputs: code latched on accept, single-cycle valid, held until release is confirmed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= row_code(w_row_nxt, r_col);
        r_key_held <= 1'b1;
      end else if (w_release_done) begin
        r_key_held <= 1'b0;
      end else begin
        r_key_held <= r_key_held;
      end
    end
  end

  assign cols_n    = r_cols_n;
  assign col_idx   = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  logic       clock;
  logic       reset_n;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [1:0] col_idx;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Keypad model: mask bit r*4+c = key (row r, column c) pressed; override forces raw rows.
  logic [15:0] mask;
  logic        ovr_en;
  logic [3:0]  ovr_val;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int vcount = 0;
  logic [3:0] act_q[$];
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[16];
  logic [3:0] code_tab[16];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .col_idx   (col_idx),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Row line level seen by the scanner for the current column strobe.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      rows_n[r] = ~(|(mask[r*4 +: 4] & ~cols_n));
    end
    if (ovr_en) rows_n = ovr_val;
  end

  // Cycle counter used to place stimulus relative to reset release.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: record every key_valid pulse with its code.
  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      act_q.push_back(key_code);
      vcount <= vcount + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    base = cyc;
  endtask

  task automatic go_to(input int p);
    while (cyc - base < p) @(negedge clock);
  endtask

  task automatic wait_held(input logic v, input string nm);
    int n = 0;
    while (key_held !== v && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(nm, key_held, v);
  endtask

  task automatic drain();
    logic [3:0] a;
    @(negedge clock);
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected key_valid: got code %0h expected no pulse", a);
      end else begin
        check("key_code at key_valid", a, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    logic [3:0] exp_cols;
    int snap;
    reset_n = 1'b0;
    mask    = 16'h0;
    ovr_en  = 1'b0;
    ovr_val = 4'hF;
    code_tab = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    for (int k = 0; k < 16; k++) begin
      vecs[k].row  = 2'(k / 4);
      vecs[k].col  = 2'(k % 4);
      vecs[k].code = code_tab[k];
    end

    // Reset values, then idle scanning with no key.
    start();
    check("reset cols_n", cols_n, 4'b1110);
    check("reset col_idx", col_idx, 2'd0);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", key_valid, 1'b0);
    check("reset key_held", key_held, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      go_to(n);
      exp_cols = ~(4'b0001 << ((n / 4) % 4));
      check("idle cols_n", cols_n, exp_cols);
      check("idle col_idx", col_idx, (n / 4) % 4);
    end
    check("idle no key_valid", vcount, 0);

    // Key row1/col2 with latency, then a one-tick release bounce.
    mask = 16'h0040;
    exp_q.push_back(4'h7);
    start();
    snap = vcount;
    go_to(19);
    check("key7 not yet valid", key_valid, 1'b0);
    go_to(20);
    check("key7 valid", key_valid, 1'b1);
    check("key7 code", key_code, 4'h7);
    check("key7 held", key_held, 1'b1);
    check("key7 col held", col_idx, 2'd2);
    go_to(21);
    check("key7 valid one cycle", key_valid, 1'b0);
    mask = 16'h0;
    go_to(25);
    mask = 16'h0040;
    go_to(29);
    check("release bounce held", key_held, 1'b1);
    mask = 16'h0;
    go_to(37);
    check("release in progress held", key_held, 1'b1);
    go_to(41);
    check("released held", key_held, 1'b0);
    check("scan resumes col_idx", col_idx, 2'd3);
    check("scan resumes cols_n", cols_n, 4'b0111);
    check("key7 single pulse", vcount - snap, 1);
    drain();

    // Press bounce: valid for one tick, then idle, twice.
    ovr_en = 1'b1;
    ovr_val = 4'b1110;
    start();
    snap = vcount;
    go_to(5);  ovr_val = 4'hF;
    go_to(9);  ovr_val = 4'b1110;
    go_to(13); ovr_val = 4'hF;
    go_to(17);
    check("bounce col_idx", col_idx, 2'd2);
    check("bounce no key_valid", vcount - snap, 0);
    check("bounce not held", key_held, 1'b0);

    // Ghosting: two rows low are never a key.
    ovr_val = 4'b1100;
    start();
    snap = vcount;
    go_to(13);
    check("ghost col_idx", col_idx, 2'd3);
    go_to(17);
    check("ghost wrap col_idx", col_idx, 2'd0);
    check("ghost no key_valid", vcount - snap, 0);
    ovr_en = 1'b0;
    ovr_val = 4'hF;
    drain();

    // Reset during DEBOUNCE on column 2.
    mask = 16'h0004;
    start();
    go_to(14);
    check("pre-reset debounce col_idx", col_idx, 2'd2);
    reset_n = 1'b0;
    #1;
    check("rst debounce cols_n", cols_n, 4'b1110);
    check("rst debounce col_idx", col_idx, 2'd0);
    check("rst debounce held", key_held, 1'b0);
    check("rst debounce valid", key_valid, 1'b0);

    // Reset during PRESSED on column 1.
    mask = 16'h0002;
    exp_q.push_back(4'h2);
    start();
    go_to(18);
    check("pressed code", key_code, 4'h2);
    check("pressed held", key_held, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst pressed held", key_held, 1'b0);
    check("rst pressed code", key_code, 4'h0);
    check("rst pressed cols_n", cols_n, 4'b1110);
    check("rst pressed col_idx", col_idx, 2'd0);
    mask = 16'h0;
    drain();

    // Sweep all 16 keys through the table.
    start();
    for (int k = 0; k < 16; k++) begin
      mask = 16'h0;
      mask[vecs[k].row * 4 + vecs[k].col] = 1'b1;
      exp_q.push_back(vecs[k].code);
      wait_held(1'b1, "sweep press held");
      drain();
      mask = 16'h0;
      wait_held(1'b0, "sweep release");
      repeat (3) @(negedge clock);
    end
    drain();
    check("scoreboard pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
